// File: rtl/tlrot_tl_bridge_if.sv
// TL-UL channel bundle shared by the host-facing and device-facing sides of
// tlrot_tl_bridge. The master modport issues A requests and consumes D
// responses; the slave modport is the opposite end.
interface tlrot_tl_bridge_if #(
   parameter int DataWidth = 32,
   parameter int SrcW      = 8,
   parameter int SzW       = 2
);
   localparam int AW  = 3 + 3 + SzW + SrcW + 32 + DataWidth / 8 + DataWidth;
   localparam int DW_ = 3 + 3 + SzW + SrcW + 1 + DataWidth + 1;

   logic           a_valid;
   logic           a_ready;
   logic [AW-1:0]  a_bits;
   logic           d_valid;
   logic           d_ready;
   logic [DW_-1:0] d_bits;

   modport master (
      output a_valid, a_bits, d_ready,
      input  a_ready, d_valid, d_bits
   );

   modport slave (
      input  a_valid, a_bits, d_ready,
      output a_ready, d_valid, d_bits
   );
endinterface

// File: rtl/tlrot_tl_bridge.sv
// TL-UL bridge from the SoC host port to one RoT device port. Buffers legal
// requests, limits outstanding transactions, answers illegal requests locally
// with denied responses and returns all responses in acceptance order.
// rst_ni keeps its historical name but is asynchronous and active-high.
module tlrot_tl_bridge #(
   parameter int          DataWidth      = 32,
   parameter int          SrcW           = 8,
   parameter int          SzW            = 2,
   parameter int          ReqDepth       = 2,
   parameter int          MaxOutstanding = 4,
   parameter logic [31:0] BaseAddr       = 32'h3B00_0000,
   parameter logic [31:0] WinSize        = 32'h0001_0000
) (
   input  logic                            clk_i,
   input  logic                            rst_ni,
   tlrot_tl_bridge_if.slave                h,
   tlrot_tl_bridge_if.master               dev,
   output logic [$clog2(MaxOutstanding):0] outstanding_o,
   output logic                            src_mismatch_o
);
   localparam int MW       = DataWidth / 8;
   localparam int AW       = 3 + 3 + SzW + SrcW + 32 + MW + DataWidth;
   localparam int MaxSz    = $clog2(MW);
   localparam int OffW     = MaxSz;
   localparam int TagW     = 1 + 3 + SzW + SrcW;
   localparam int TPtrW    = $clog2(MaxOutstanding);
   localparam int OCntW    = TPtrW + 1;
   localparam int RPtrW    = (ReqDepth > 1) ? $clog2(ReqDepth) : 1;
   localparam int RCntW    = $clog2(ReqDepth + 1);
   localparam int AMaskLsb = DataWidth;
   localparam int AAddrLsb = AMaskLsb + MW;
   localparam int ASrcLsb  = AAddrLsb + 32;
   localparam int ASizeLsb = ASrcLsb + SrcW;
   localparam int AOpLsb   = ASizeLsb + SzW + 3;
   localparam int DSrcLsb  = DataWidth + 2;
   localparam int DSizeLsb = DSrcLsb + SrcW;

   logic [2:0]       w_aOpcode;
   logic [SzW-1:0]   w_aSize;
   logic [SrcW-1:0]  w_aSource;
   logic [31:0]      w_aAddr;
   logic [MW-1:0]    w_aMask;
   logic [31:0]      w_addrOff;
   logic [31:0]      w_bytes;
   logic [MW-1:0]    w_expMask;
   logic             w_opOk, w_winOk, w_sizeOk, w_alignOk, w_maskOk, w_legal;
   logic             w_aReady, w_accept, w_reqPush, w_reqPop, w_dDone;
   logic             w_tagEmpty, w_headErr;
   logic [2:0]       w_headOp, w_errOp;
   logic [SzW-1:0]   w_headSize;
   logic [SrcW-1:0]  w_headSrc;
   logic [TagW-1:0]  w_headTag;

   logic             r_rstDone;
   logic [AW-1:0]    r_reqMem [ReqDepth];
   logic [RPtrW-1:0] r_reqWr, r_reqRd;
   logic [RCntW-1:0] r_reqCnt;
   logic [TagW-1:0]  r_tagMem [MaxOutstanding];
   logic [TPtrW-1:0] r_tagWr, r_tagRd;
   logic [OCntW-1:0] r_outstanding;
   logic             r_srcMismatch;

   function automatic logic [RPtrW-1:0] reqNext(input logic [RPtrW-1:0] p);
      return (int'(p) == ReqDepth - 1) ? '0 : p + 1'b1;
   endfunction

   assign w_aOpcode = h.a_bits[AOpLsb +: 3];
   assign w_aSize   = h.a_bits[ASizeLsb +: SzW];
   assign w_aSource = h.a_bits[ASrcLsb +: SrcW];
   assign w_aAddr   = h.a_bits[AAddrLsb +: 32];
   assign w_aMask   = h.a_bits[AMaskLsb +: MW];

   // Classify the request on the host A channel as legal or locally denied
   always_comb begin
      w_addrOff = w_aAddr - BaseAddr;
      w_opOk    = (w_aOpcode == 3'd0) || (w_aOpcode == 3'd1) || (w_aOpcode == 3'd4);
      w_winOk   = (w_aAddr >= BaseAddr) && (w_addrOff < WinSize);
      w_sizeOk  = (int'(w_aSize) <= MaxSz);
      w_bytes   = 32'd1 << w_aSize;
      w_alignOk = ((w_aAddr & (w_bytes - 32'd1)) == 32'd0);
      w_expMask = '0;
      for (int i = 0; i < MW; i++) begin
         w_expMask[i] = (i >= int'(w_aAddr[OffW-1:0])) &&
                        (i < int'(w_aAddr[OffW-1:0]) + int'(w_bytes));
      end
      w_maskOk  = (w_aOpcode != 3'd0) || (w_aMask == w_expMask);
      w_legal   = w_opOk && w_winOk && w_sizeOk && w_alignOk && w_maskOk;
   end

   assign w_aReady  = r_rstDone && (r_reqCnt != RCntW'(ReqDepth)) &&
                      (r_outstanding < OCntW'(MaxOutstanding));
   assign h.a_ready = w_aReady;
   assign w_accept  = h.a_valid && w_aReady;
   assign w_reqPush = w_accept && w_legal;
   assign w_reqPop  = (r_reqCnt != '0) && dev.a_ready;

   assign dev.a_valid = (r_reqCnt != '0);
   assign dev.a_bits  = r_reqMem[r_reqRd];

   // Hold h_a_ready low until the first clock after reset is released
   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) r_rstDone <= 1'b0;
      else        r_rstDone <= 1'b1;
   end

   // Request FIFO storage; only legal requests are written
   always_ff @(posedge clk_i) begin
      if (w_reqPush) r_reqMem[r_reqWr] <= h.a_bits;
   end

   // Request FIFO pointers and occupancy
   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         r_reqWr  <= '0;
         r_reqRd  <= '0;
         r_reqCnt <= '0;
      end else begin
         if (w_reqPush) r_reqWr <= reqNext(r_reqWr);
         if (w_reqPop)  r_reqRd <= reqNext(r_reqRd);
         r_reqCnt <= r_reqCnt + RCntW'(w_reqPush) - RCntW'(w_reqPop);
      end
   end

   // Tag FIFO storage; every accepted request leaves a tag to order responses
   always_ff @(posedge clk_i) begin
      if (w_accept) r_tagMem[r_tagWr] <= {~w_legal, w_aOpcode, w_aSize, w_aSource};
   end

   assign w_headTag  = r_tagMem[r_tagRd];
   assign w_headErr  = w_headTag[TagW-1];
   assign w_headOp   = w_headTag[SzW + SrcW +: 3];
   assign w_headSize = w_headTag[SrcW +: SzW];
   assign w_headSrc  = w_headTag[0 +: SrcW];
   assign w_tagEmpty = (r_outstanding == '0);
   assign w_errOp    = (w_headOp == 3'd4) ? 3'd1 : 3'd0;

   // Drive the host D channel from the head tag: local denial or device response
   always_comb begin
      h.d_valid   = 1'b0;
      h.d_bits    = '0;
      dev.d_ready = 1'b0;
      if (!w_tagEmpty) begin
         if (w_headErr) begin
            h.d_valid = 1'b1;
            h.d_bits  = {w_errOp, 3'd0, w_headSize, w_headSrc, 1'b0, {DataWidth{1'b0}}, 1'b1};
         end else begin
            h.d_valid                   = dev.d_valid;
            h.d_bits                    = dev.d_bits;
            h.d_bits[DSrcLsb +: SrcW]   = w_headSrc;
            h.d_bits[DSizeLsb +: SzW]   = w_headSize;
            dev.d_ready                 = h.d_ready;
         end
      end
   end

   assign w_dDone = h.d_valid && h.d_ready;

   // Tag FIFO pointers and the outstanding count, which is also its occupancy
   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) begin
         r_tagWr       <= '0;
         r_tagRd       <= '0;
         r_outstanding <= '0;
      end else begin
         if (w_accept) r_tagWr <= r_tagWr + 1'b1;
         if (w_dDone)  r_tagRd <= r_tagRd + 1'b1;
         r_outstanding <= r_outstanding + OCntW'(w_accept) - OCntW'(w_dDone);
      end
   end

   // Sticky flag for a device response whose source differs from the head tag
   always_ff @(posedge clk_i or posedge rst_ni) begin
      if (rst_ni) r_srcMismatch <= 1'b0;
      else if (dev.d_valid && dev.d_ready && (dev.d_bits[DSrcLsb +: SrcW] != w_headSrc))
         r_srcMismatch <= 1'b1;
   end

   assign outstanding_o  = r_outstanding;
   assign src_mismatch_o = r_srcMismatch;
endmodule

// File: tb/tb_tlrot_tl_bridge.sv
// Directed bench for tlrot_tl_bridge on the 32-bit register path. The bench
// plays both the host and the device and checks every response by hand value.
module tb_tlrot_tl_bridge;
   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [2:0] outstanding_o;
   logic       src_mismatch_o;
   int         errors = 0;
   int         checks = 0;

   typedef struct {
      logic [2:0]  op;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [3:0]  mask;
      logic        legal;
   } vec_t;

   vec_t       vecs [9];
   logic [7:0] src;
   logic [2:0] expOp;

   tlrot_tl_bridge_if #(.DataWidth(32), .SrcW(8), .SzW(2)) hostIf ();
   tlrot_tl_bridge_if #(.DataWidth(32), .SrcW(8), .SzW(2)) devIf ();

   tlrot_tl_bridge dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .h              (hostIf),
      .dev            (devIf),
      .outstanding_o  (outstanding_o),
      .src_mismatch_o (src_mismatch_o)
   );

   // Free-running 10 ns clock
   always #5 clk_i = ~clk_i;

   function automatic logic [83:0] mkA(input logic [2:0] op, input logic [1:0] size,
                                       input logic [7:0] s, input logic [31:0] addr,
                                       input logic [3:0] mask, input logic [31:0] data);
      return {op, 3'd0, size, s, addr, mask, data};
   endfunction

   function automatic logic [49:0] mkD(input logic [2:0] op, input logic [1:0] size,
                                       input logic [7:0] s, input logic [31:0] data,
                                       input logic denied);
      return {op, 3'd0, size, s, 1'b0, data, denied};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic [2:0] op, input logic [1:0] size,
                                input logic [7:0] s, input logic [31:0] addr,
                                input logic [3:0] mask);
      hostIf.a_valid = 1'b1;
      hostIf.a_bits  = mkA(op, size, s, addr, mask, 32'hA5A5_0000 | {24'd0, s});
   endtask

   task automatic tick;
      @(posedge clk_i);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      hostIf.a_valid = 1'b0;
      hostIf.a_bits  = '0;
      hostIf.d_ready = 1'b0;
      devIf.a_ready  = 1'b0;
      devIf.d_valid  = 1'b0;
      devIf.d_bits   = '0;
      vecs[0] = '{3'd1, 2'd2, 32'h3B00_FFFC, 4'b0101, 1'b1};
      vecs[1] = '{3'd4, 2'd2, 32'h3B01_0000, 4'hF,    1'b0};
      vecs[2] = '{3'd4, 2'd2, 32'h3AFF_FFFC, 4'hF,    1'b0};
      vecs[3] = '{3'd4, 2'd1, 32'h3B00_0002, 4'b1100, 1'b1};
      vecs[4] = '{3'd4, 2'd1, 32'h3B00_0001, 4'b0110, 1'b0};
      vecs[5] = '{3'd4, 2'd3, 32'h3B00_0000, 4'hF,    1'b0};
      vecs[6] = '{3'd2, 2'd2, 32'h3B00_0000, 4'hF,    1'b0};
      vecs[7] = '{3'd0, 2'd1, 32'h3B00_0002, 4'b1100, 1'b1};
      vecs[8] = '{3'd0, 2'd1, 32'h3B00_0002, 4'b0011, 1'b0};

      // Reset state
      rst_ni = 1'b0;
      #1 rst_ni = 1'b1;
      #1;
      checkOutput("rst_h_a_ready", hostIf.a_ready, 0);
      checkOutput("rst_h_d_valid", hostIf.d_valid, 0);
      checkOutput("rst_dev_a_valid", devIf.a_valid, 0);
      checkOutput("rst_outstanding", outstanding_o, 0);
      checkOutput("rst_src_mismatch", src_mismatch_o, 0);
      tick;
      tick;
      rst_ni = 1'b0;
      settle;
      checkOutput("rel_h_a_ready_same", hostIf.a_ready, 0);
      tick;
      checkOutput("rel_h_a_ready_next", hostIf.a_ready, 1);

      // Legal Get answered by the device
      applyStimulus(3'd4, 2'd2, 8'h05, 32'h3B00_0010, 4'hF);
      settle;
      checkOutput("get_a_ready", hostIf.a_ready, 1);
      checkOutput("get_dev_a_before", devIf.a_valid, 0);
      tick;
      hostIf.a_valid = 1'b0;
      settle;
      checkOutput("get_dev_a_valid", devIf.a_valid, 1);
      checkOutput("get_dev_a_bits", devIf.a_bits,
                  mkA(3'd4, 2'd2, 8'h05, 32'h3B00_0010, 4'hF, 32'hA5A5_0005));
      checkOutput("get_outstanding", outstanding_o, 1);
      devIf.a_ready = 1'b1;
      tick;
      settle;
      checkOutput("get_dev_a_drained", devIf.a_valid, 0);
      devIf.d_valid  = 1'b1;
      devIf.d_bits   = mkD(3'd1, 2'd2, 8'h05, 32'hDEAD_BEEF, 1'b0);
      hostIf.d_ready = 1'b1;
      settle;
      checkOutput("get_h_d_valid", hostIf.d_valid, 1);
      checkOutput("get_h_d_bits", hostIf.d_bits, mkD(3'd1, 2'd2, 8'h05, 32'hDEAD_BEEF, 1'b0));
      checkOutput("get_dev_d_ready", devIf.d_ready, 1);
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("get_outstanding_done", outstanding_o, 0);

      // Out-of-window Get answered locally
      applyStimulus(3'd4, 2'd2, 8'h07, 32'h1000_0000, 4'hF);
      tick;
      hostIf.a_valid = 1'b0;
      settle;
      checkOutput("oow_dev_a_valid", devIf.a_valid, 0);
      checkOutput("oow_h_d_valid", hostIf.d_valid, 1);
      checkOutput("oow_h_d_bits", hostIf.d_bits, mkD(3'd1, 2'd2, 8'h07, 32'h0, 1'b1));
      checkOutput("oow_outstanding", outstanding_o, 1);
      tick;
      checkOutput("oow_outstanding_done", outstanding_o, 0);
      checkOutput("oow_dev_a_still_idle", devIf.a_valid, 0);

      // In-order return: legal, illegal PutFull, legal, with a stalled device
      applyStimulus(3'd4, 2'd2, 8'h01, 32'h3B00_0020, 4'hF);
      tick;
      applyStimulus(3'd0, 2'd2, 8'h02, 32'h3B00_0024, 4'b0011);
      tick;
      applyStimulus(3'd4, 2'd2, 8'h03, 32'h3B00_0028, 4'hF);
      tick;
      hostIf.a_valid = 1'b0;
      settle;
      checkOutput("order_outstanding", outstanding_o, 3);
      for (int i = 0; i < 10; i++) begin
         checkOutput($sformatf("order_stall_h_d_valid_%0d", i), hostIf.d_valid, 0);
         tick;
      end
      devIf.d_valid = 1'b1;
      devIf.d_bits  = mkD(3'd1, 2'd2, 8'h01, 32'h1111_1111, 1'b0);
      settle;
      checkOutput("order_first_bits", hostIf.d_bits, mkD(3'd1, 2'd2, 8'h01, 32'h1111_1111, 1'b0));
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("order_second_valid", hostIf.d_valid, 1);
      checkOutput("order_second_bits", hostIf.d_bits, mkD(3'd0, 2'd2, 8'h02, 32'h0, 1'b1));
      tick;
      settle;
      checkOutput("order_third_wait", hostIf.d_valid, 0);
      devIf.d_valid = 1'b1;
      devIf.d_bits  = mkD(3'd1, 2'd2, 8'h03, 32'h3333_3333, 1'b0);
      settle;
      checkOutput("order_third_bits", hostIf.d_bits, mkD(3'd1, 2'd2, 8'h03, 32'h3333_3333, 1'b0));
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("order_outstanding_done", outstanding_o, 0);

      // Outstanding limit with a silent device
      for (int i = 0; i < 5; i++) begin
         applyStimulus(3'd4, 2'd2, 8'(8'h10 + i), 32'(32'h3B00_0040 + 4 * i), 4'hF);
         settle;
         checkOutput($sformatf("lim_a_ready_%0d", i), hostIf.a_ready, (i < 4) ? 1 : 0);
         tick;
      end
      settle;
      checkOutput("lim_outstanding_full", outstanding_o, 4);
      checkOutput("lim_a_ready_full", hostIf.a_ready, 0);
      devIf.d_valid = 1'b1;
      devIf.d_bits  = mkD(3'd1, 2'd2, 8'h10, 32'h0, 1'b0);
      settle;
      checkOutput("lim_resp_valid", hostIf.d_valid, 1);
      checkOutput("lim_a_ready_same_cycle", hostIf.a_ready, 0);
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("lim_outstanding_after_resp", outstanding_o, 3);
      checkOutput("lim_a_ready_after_resp", hostIf.a_ready, 1);
      tick;
      hostIf.a_valid = 1'b0;
      settle;
      checkOutput("lim_outstanding_fifth", outstanding_o, 4);
      devIf.d_valid = 1'b1;
      devIf.d_bits  = mkD(3'd1, 2'd2, 8'h11, 32'h0, 1'b0);
      tick;
      devIf.d_bits  = mkD(3'd1, 2'd2, 8'h12, 32'h0, 1'b0);
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("lim_outstanding_two", outstanding_o, 2);

      // Reset with three transactions outstanding
      devIf.a_ready = 1'b0;
      applyStimulus(3'd4, 2'd2, 8'h15, 32'h3B00_0060, 4'hF);
      tick;
      hostIf.a_valid = 1'b0;
      hostIf.d_ready = 1'b0;
      devIf.d_valid  = 1'b1;
      devIf.d_bits   = mkD(3'd1, 2'd2, 8'h13, 32'h0, 1'b0);
      settle;
      checkOutput("mid_dev_a_valid", devIf.a_valid, 1);
      checkOutput("mid_h_d_valid", hostIf.d_valid, 1);
      checkOutput("mid_outstanding", outstanding_o, 3);
      rst_ni = 1'b1;
      settle;
      checkOutput("mid_rst_h_d_valid", hostIf.d_valid, 0);
      checkOutput("mid_rst_dev_a_valid", devIf.a_valid, 0);
      checkOutput("mid_rst_outstanding", outstanding_o, 0);
      checkOutput("mid_rst_h_a_ready", hostIf.a_ready, 0);
      devIf.d_valid = 1'b0;
      tick;
      tick;
      rst_ni = 1'b0;
      tick;
      devIf.a_ready  = 1'b1;
      hostIf.d_ready = 1'b1;
      checkOutput("mid_rel_h_a_ready", hostIf.a_ready, 1);

      // Device returns the wrong source
      applyStimulus(3'd4, 2'd2, 8'h05, 32'h3B00_0030, 4'hF);
      tick;
      hostIf.a_valid = 1'b0;
      devIf.d_valid  = 1'b1;
      devIf.d_bits   = mkD(3'd1, 2'd2, 8'h09, 32'hCAFE_F00D, 1'b0);
      settle;
      checkOutput("mis_h_d_bits", hostIf.d_bits, mkD(3'd1, 2'd2, 8'h05, 32'hCAFE_F00D, 1'b0));
      checkOutput("mis_flag_before", src_mismatch_o, 0);
      tick;
      devIf.d_valid = 1'b0;
      settle;
      checkOutput("mis_flag_set", src_mismatch_o, 1);
      tick;
      tick;
      checkOutput("mis_flag_held", src_mismatch_o, 1);
      checkOutput("mis_outstanding", outstanding_o, 0);

      // Window, size, alignment, opcode and mask boundaries
      for (int i = 0; i < 9; i++) begin
         src   = 8'(8'h20 + i);
         expOp = (vecs[i].op == 3'd4) ? 3'd1 : 3'd0;
         applyStimulus(vecs[i].op, vecs[i].size, src, vecs[i].addr, vecs[i].mask);
         tick;
         hostIf.a_valid = 1'b0;
         settle;
         checkOutput($sformatf("bnd_dev_a_valid_%0d", i), devIf.a_valid, vecs[i].legal);
         if (vecs[i].legal) begin
            devIf.d_valid = 1'b1;
            devIf.d_bits  = mkD(expOp, vecs[i].size, src, 32'h0, 1'b0);
            settle;
         end
         checkOutput($sformatf("bnd_h_d_valid_%0d", i), hostIf.d_valid, 1);
         checkOutput($sformatf("bnd_h_d_bits_%0d", i), hostIf.d_bits,
                     mkD(expOp, vecs[i].size, src, 32'h0, ~vecs[i].legal));
         tick;
         devIf.d_valid = 1'b0;
         settle;
         checkOutput($sformatf("bnd_outstanding_%0d", i), outstanding_o, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/tlrot_tl_bridge.md
Name: tlrot_tl_bridge

Overview:
- Parametrised TL-UL bridge between the SoC-facing TileLink port and one RoT device port (peripheral crossbar or ROM window).
- Adds what the flat wiring lacked: a request buffer, an outstanding-transaction limit, address-window and legality checking with locally generated error responses, and in-order response return with source checking.
- One instance serves the 32-bit register path (DataWidth=32) and one the 64-bit ROM path (DataWidth=64).

Parameters:
- DataWidth, 32, data bus width; 32 or 64.
- SrcW, 8, width of the source field.
- SzW, 2, width of the size field; 3 on the 64-bit path.
- ReqDepth, 2, request FIFO entries; must be ≥1.
- MaxOutstanding, 4, maximum accepted but unresponded transactions; power of 2, ≥2.
- BaseAddr, 32'h3B00_0000, start of the legal address window.
- WinSize, 32'h0001_0000, window size in bytes; power of 2.

Ports:
- clk_i  input  1  sole clock.
- rst_ni  input  1  reset, asynchronous, active-high. The codebase name is kept; asserted = 1.
- h_a_valid  input  1  host A valid.
- h_a_ready  output  1  host A ready.
- h_a_bits  input  AW  packed {opcode[2:0], param[2:0], size[SzW-1:0], source[SrcW-1:0], address[31:0], mask[DataWidth/8-1:0], data[DataWidth-1:0]}.
- h_d_valid  output  1  host D valid.
- h_d_ready  input  1  host D ready.
- h_d_bits  output  DW_  packed {opcode[2:0], param[2:0], size, source, sink[0], data, denied}.
- dev_a_valid / dev_a_ready  output / input  1  device A handshake.
- dev_a_bits  output  AW  same packing as h_a_bits.
- dev_d_valid / dev_d_ready  input / output  1  device D handshake.
- dev_d_bits  input  DW_  same packing as h_d_bits.
- outstanding_o  output  clog2(MaxOutstanding)+1  current outstanding count.
- src_mismatch_o  output  1  sticky flag: device response source differed from the expected source.

Behaviour:
- Reset (asynchronous, rst_ni=1): all FIFOs empty, outstanding_o=0, src_mismatch_o=0, h_d_valid=0, dev_a_valid=0, h_a_ready=0.
- Accept rule: h_a_ready = request FIFO not full && outstanding_o < MaxOutstanding. A request is accepted on h_a_valid && h_a_ready.
- Legality check, done at accept. A request is illegal if any of the following holds:
  - opcode not in {0 PutFull, 1 PutPartial, 4 Get};
  - address outside [BaseAddr, BaseAddr+WinSize);
  - 2^size > DataWidth/8;
  - address not aligned to 2^size;
  - PutFull whose mask does not cover exactly the 2^size bytes.
- Every accepted request:
  - increments the outstanding count;
  - pushes a tag {err, opcode, size, source} into the tag FIFO (depth MaxOutstanding).
- Only legal requests are pushed into the request FIFO. The FIFO drives dev_a_*; its head is presented with dev_a_valid=1 and held stable until dev_a_ready.
- Minimum latency, h_a accept to dev_a_valid: 1 cycle (registered FIFO output; no combinational A path).
- Responses return strictly in acceptance order, driven by the tag FIFO head.
- Head tag err=1 (local error response):
  - h_d_valid=1 without waiting on the device;
  - d_opcode = 1 (AccessAckData) for Get, else 0 (AccessAck);
  - d_size and d_source from the tag; d_data=0; d_denied=1; d_param=0; d_sink=0.
- Head tag err=0 (device response):
  - h_d_valid = dev_d_valid and h_d_bits = dev_d_bits, except d_source and d_size, which are taken from the tag;
  - dev_d_ready = h_d_ready;
  - if dev_d_source ≠ tag source at the handshake, set src_mismatch_o; it stays set until reset.
- dev_d_ready = 0 whenever the tag FIFO is empty or the head tag has err=1. An unexpected dev_d_valid is stalled, not dropped.
- On h_d_valid && h_d_ready: pop the tag; decrement the outstanding count.
- Accept and response completion in the same cycle: the count stays the same. With count = MaxOutstanding, h_a_ready stays 0 in that cycle; the new value is seen next cycle.
- Counts never wrap: the counter saturates logically by construction. Underflow is impossible because a pop requires a tag.
- Reset mid-transfer discards all buffered requests and tags. The device must share the reset.

Test Plan:
- Reset pulse → all outputs 0. After release, h_a_ready=1 next cycle.
- Get at 0x3B00_0010, size 2, source 0x05; device returns data 0xDEAD_BEEF → dev_a_valid exactly 1 cycle after accept. h_d: opcode 1, data 0xDEAD_BEEF, source 0x05, denied 0.
- Out-of-window Get at 0x1000_0000, source 0x07 → no dev_a_valid. h_d: opcode 1, denied 1, data 0, source 0x07; outstanding_o back to 0.
- Legal Get (src 1), illegal PutFull (src 2), legal Get (src 3), device stalls its response 10 cycles → h_d returns in order 1, 2, 3; the src 2 error response is not issued before src 1 completes.
- 5 legal Gets back-to-back, device never responds (MaxOutstanding=4) → h_a_ready drops after the 4th accept; outstanding_o=4; 5th accepted only after one response.
- Device returns source 0x09 while the head tag is 0x05 → h_d_source=0x05, src_mismatch_o=1 and held.
- Assert rst_ni while 3 requests are outstanding → same cycle: h_d_valid=0, dev_a_valid=0, outstanding_o=0.
